// File: rtl/async_ram_master.sv
// async_ram_master
//   Synchronous bus master for an asynchronous single-port RAM. A one-cycle
//   host request is turned into a timed sequence on the RAM pins:
//   address/data setup, strobe, hold, then a one-cycle ack pulse to the host.
//   Read data is captured into rdata on the last strobe edge.
//
//   Optional build macro TURNAROUND_EN: after a write, one extra dead cycle
//   (TURN) keeps the bus undriven before the next request can be accepted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req, rw           host request (sampled in IDLE only), 1 = write
//   host_addr, wdata  transaction address / write data, sampled with req
//   rdata             last captured read data
//   ack               one-cycle completion pulse
//   busy              high while a transaction is in progress
//   ram_re, ram_we    RAM strobes (active high)
//   ram_addr          RAM address
//   ram_data          shared tri-state data bus, driven only for writes
module async_ram_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int MAX_SA  = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int MAX_CYC = (MAX_SA > HOLD_CYC) ? MAX_SA : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

`ifdef TURNAROUND_EN
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE, TURN} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;
`endif

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               rw_q;
  logic [DATA_W-1:0]  dout;
  logic               drive_en;
  logic               accept;
  logic               capture;

  // The master is the only driver of the bus during a write; otherwise the
  // RAM (on reads) or nobody owns it.
  assign ram_data = drive_en ? dout : {DATA_W{1'bz}};

  assign accept  = (state == IDLE) && req;
  assign capture = (state == ACCESS) && (cnt == '0) && !rw_q;

  // Next-state logic. Each timed phase loads its counter with N-1 on entry
  // and advances when it reaches zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_n = SETUP;
          cnt_n   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = ACCESS;
          cnt_n   = CNT_W'(ACCESS_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef TURNAROUND_EN
      DONE:    state_n = rw_q ? TURN : IDLE;
      TURN:    state_n = IDLE;
`else
      DONE:    state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // All outputs are registered from the next state, so they line up with
  // the state they belong to and never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rw_q     <= 1'b0;
      dout     <= '0;
      drive_en <= 1'b0;
      ram_addr <= '0;
      ram_re   <= 1'b0;
      ram_we   <= 1'b0;
      rdata    <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        rw_q     <= rw;
        ram_addr <= host_addr;
        dout     <= wdata;
      end
      // Drive from SETUP through HOLD of a write; released on entry to DONE.
      drive_en <= accept ? rw
                         : (drive_en && (state_n inside {SETUP, ACCESS, HOLD}));
      // Strobes only rise on entry to ACCESS, at least one cycle after the
      // address was updated on the accepting edge.
      ram_we <= rw_q  && (state_n == ACCESS);
      ram_re <= !rw_q && (state_n == ACCESS);
      if (capture)
        rdata <= ram_data;
      // Registered from DONE: the pulse lands in the cycle after DONE.
      ack  <= (state == DONE);
      busy <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_async_ram_master.sv
// tb_async_ram_master
//   Directed self-checking bench for async_ram_master. Two instances: one
//   with default timing, one with SETUP=2/ACCESS=3/HOLD=2. Each has a simple
//   behavioural asynchronous RAM model on its bus.
module tb_async_ram_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        req = 1'b0, rw = 1'b0;
  logic [2:0]  host_addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ack, busy, ram_re, ram_we;
  logic [2:0]  ram_addr;
  wire  [15:0] ram_data;

  // swept instance
  logic        req2 = 1'b0, rw2 = 1'b0;
  logic [2:0]  host_addr2 = '0;
  logic [15:0] wdata2 = '0;
  logic [15:0] rdata2;
  logic        ack2, busy2, ram_re2, ram_we2;
  logic [2:0]  ram_addr2;
  wire  [15:0] ram_data2;

  async_ram_master dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .host_addr(host_addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
    .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  async_ram_master #(.SETUP_CYC(2), .ACCESS_CYC(3), .HOLD_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .rw(rw2), .host_addr(host_addr2),
    .wdata(wdata2), .rdata(rdata2), .ack(ack2), .busy(busy2),
    .ram_re(ram_re2), .ram_we(ram_we2), .ram_addr(ram_addr2), .ram_data(ram_data2)
  );

  // RAM models
  logic [15:0] mem  [8] = '{default: 16'h0000};
  logic [15:0] mem2 [8] = '{default: 16'h0000};
  assign ram_data  = ram_re  ? mem[ram_addr]   : 16'hzzzz;
  assign ram_data2 = ram_re2 ? mem2[ram_addr2] : 16'hzzzz;
  always @(posedge clk) if (ram_we)  mem[ram_addr]   <= ram_data;
  always @(posedge clk) if (ram_we2) mem2[ram_addr2] <= ram_data2;

  // bus monitor on the default instance
  int coll = 0, bus_bad = 0, acc2 = 0;
  always @(negedge clk) begin
    if (ram_re && ram_we) coll <= coll + 1;
    if (ram_re && (ram_data !== mem[ram_addr])) bus_bad <= bus_bad + 1;
    if ((ram_re || ram_we) && ram_addr == 3'd2) acc2 <= acc2 + 1;
  end

  int tests = 0, fails = 0;

  // An undriven bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
  function automatic bit released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  // Called at a negedge: issues one request and returns at the negedge where
  // ack is seen; lat is the number of edges from accept to ack, -1 on timeout.
  task automatic do_txn(input bit w, input logic [2:0] a, input logic [15:0] d,
                        output int lat);
    req = 1'b1; rw = w; host_addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (ack) begin lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; rw = 1'b1; host_addr = 3'd7; wdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    tests++; if ({ram_re, ram_we} !== 2'b00) begin fails++; $display("FAIL reset_strobes got %b want 00", {ram_re, ram_we}); end
    tests++; if (ram_addr !== 3'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
    tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    tests++; if ({ack, busy} !== 2'b00) begin fails++; $display("FAIL reset_ack_busy got %b want 00", {ack, busy}); end
    tests++; if (!released(ram_data)) begin fails++; $display("FAIL reset_bus got %h want released", ram_data); end
    req = 1'b0; rw = 1'b0; host_addr = '0; wdata = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [15:0] dv [8];
    logic [2:0]  av [8];
    logic        wv [8], kv [8], bv [8];
    int we_cnt, we_first, ack_cnt, ack_idx;
    bit data_ok;
    req = 1'b1; rw = 1'b1; host_addr = 3'd5; wdata = 16'hA5C3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req = 1'b0;
      dv[k] = ram_data; av[k] = ram_addr; wv[k] = ram_we; kv[k] = ack; bv[k] = busy;
    end
    we_cnt = 0; we_first = -1; ack_cnt = 0; ack_idx = -1; data_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (wv[k]) begin we_cnt++; if (we_first < 0) we_first = k; end
      if (kv[k]) begin ack_cnt++; if (ack_idx < 0) ack_idx = k; end
    end
    for (int k = 0; k < 4; k++) if (dv[k] !== 16'hA5C3) data_ok = 1'b0;
    tests++; if (av[0] !== 3'd5 || av[7] !== 3'd5) begin fails++; $display("FAIL wr_addr got %0d/%0d want 5/5", av[0], av[7]); end
    tests++; if (we_cnt != 2) begin fails++; $display("FAIL wr_we_width got %0d want 2", we_cnt); end
    tests++; if (we_first != 1) begin fails++; $display("FAIL wr_we_start got %0d want 1", we_first); end
    tests++; if (!data_ok) begin fails++; $display("FAIL wr_bus_data got %h %h %h %h want a5c3", dv[0], dv[1], dv[2], dv[3]); end
    tests++; if (!released(dv[4])) begin fails++; $display("FAIL wr_bus_release got %h want released", dv[4]); end
    tests++; if (ack_cnt != 1 || ack_idx != 5) begin fails++; $display("FAIL wr_ack got cnt %0d idx %0d want 1/5", ack_cnt, ack_idx); end
    tests++; if (bv[4] !== 1'b1 || bv[5] !== 1'b0) begin fails++; $display("FAIL wr_busy got %b%b want 10", bv[4], bv[5]); end
    tests++; if (mem[5] !== 16'hA5C3) begin fails++; $display("FAIL wr_mem got %h want a5c3", mem[5]); end
  endtask

  task automatic test_write_read_all();
    logic [15:0] exp_d [8];
    int lat, c0, b0, bad_lat;
    c0 = coll; b0 = bus_bad; bad_lat = 0;
    for (int a = 0; a < 8; a++) exp_d[a] = 16'($urandom % 65536);
    for (int a = 0; a < 8; a++) begin
      do_txn(1'b1, 3'(a), exp_d[a], lat);
      if (lat != 5) bad_lat++;
    end
    for (int a = 0; a < 8; a++) begin
      do_txn(1'b0, 3'(a), 16'h0, lat);
      if (lat != 5) bad_lat++;
      tests++; if (rdata !== exp_d[a]) begin fails++; $display("FAIL rd_addr%0d got %h want %h", a, rdata, exp_d[a]); end
    end
    tests++; if (bad_lat != 0) begin fails++; $display("FAIL rw_latency got %0d bad want 0", bad_lat); end
    tests++; if (coll != c0) begin fails++; $display("FAIL strobe_overlap got %0d want 0", coll - c0); end
    tests++; if (bus_bad != b0) begin fails++; $display("FAIL bus_contention got %0d want 0", bus_bad - b0); end
  endtask

  task automatic test_busy_reject();
    int a0, acks;
    logic [15:0] m2;
    a0 = acc2; m2 = mem[2]; acks = 0;
    req = 1'b1; rw = 1'b1; host_addr = 3'd1; wdata = 16'h1111;
    @(negedge clk);                       // SETUP
    req = 1'b0;
    if (ack) acks++;
    @(negedge clk);                       // ACCESS
    if (ack) acks++;
    req = 1'b1; rw = 1'b1; host_addr = 3'd2; wdata = 16'h2222;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    tests++; if (acks != 1) begin fails++; $display("FAIL busy_acks got %0d want 1", acks); end
    tests++; if (acc2 != a0) begin fails++; $display("FAIL busy_addr2_access got %0d want 0", acc2 - a0); end
    tests++; if (mem[2] !== m2 || mem[1] !== 16'h1111) begin fails++; $display("FAIL busy_mem got %h/%h want %h/1111", mem[2], mem[1], m2); end
  endtask

  task automatic test_mid_reset();
    int lat, acks;
    do_txn(1'b1, 3'd6, 16'hBEEF, lat);
    do_txn(1'b0, 3'd6, 16'h0, lat);
    tests++; if (rdata !== 16'hBEEF) begin fails++; $display("FAIL mr_pre_rdata got %h want beef", rdata); end
    req = 1'b1; rw = 1'b0; host_addr = 3'd6;
    @(negedge clk);                       // SETUP
    req = 1'b0;
    @(negedge clk);                       // ACCESS
    tests++; if (ram_re !== 1'b1) begin fails++; $display("FAIL mr_re_active got %b want 1", ram_re); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({ram_re, ram_we, busy, ack} !== 4'b0000) begin fails++; $display("FAIL mr_ctrl got %b want 0000", {ram_re, ram_we, busy, ack}); end
    tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL mr_rdata got %h want 0000", rdata); end
    tests++; if (!released(ram_data)) begin fails++; $display("FAIL mr_bus got %h want released", ram_data); end
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    tests++; if (acks != 0) begin fails++; $display("FAIL mr_no_ack got %0d want 0", acks); end
  endtask

  task automatic test_back_to_back();
    int lat, wait_cyc, exp_wait;
`ifdef TURNAROUND_EN
    exp_wait = 2;
`else
    exp_wait = 1;
`endif
    do_txn(1'b1, 3'd3, 16'h0F0F, lat);
    // Request the read in the ack cycle and hold it until it is taken.
    req = 1'b1; rw = 1'b0; host_addr = 3'd3;
    wait_cyc = -1;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (busy) begin wait_cyc = k; break; end
    end
    req = 1'b0;
    tests++; if (wait_cyc != exp_wait) begin fails++; $display("FAIL b2b_accept got %0d want %0d", wait_cyc, exp_wait); end
    lat = -1;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (ack) begin lat = i; break; end
    end
    tests++; if (lat != 5) begin fails++; $display("FAIL b2b_rd_latency got %0d want 5", lat); end
    tests++; if (rdata !== 16'h0F0F) begin fails++; $display("FAIL b2b_rdata got %h want 0f0f", rdata); end
  endtask

  task automatic test_param_sweep();
    int st_cnt, st_first, ack_idx;
    // write
    req2 = 1'b1; rw2 = 1'b1; host_addr2 = 3'd4; wdata2 = 16'h1234;
    st_cnt = 0; st_first = -1; ack_idx = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req2 = 1'b0;
      if (ram_we2) begin st_cnt++; if (st_first < 0) st_first = k; end
      if (ack2 && ack_idx < 0) ack_idx = k;
    end
    tests++; if (st_cnt != 3 || st_first != 2) begin fails++; $display("FAIL sweep_we got width %0d start %0d want 3/2", st_cnt, st_first); end
    tests++; if (ack_idx != 8) begin fails++; $display("FAIL sweep_wr_ack got %0d want 8", ack_idx); end
    // read back
    req2 = 1'b1; rw2 = 1'b0; host_addr2 = 3'd4;
    st_cnt = 0; ack_idx = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req2 = 1'b0;
      if (ram_re2) st_cnt++;
      if (ack2 && ack_idx < 0) ack_idx = k;
    end
    tests++; if (st_cnt != 3 || ack_idx != 8) begin fails++; $display("FAIL sweep_re got width %0d ack %0d want 3/8", st_cnt, ack_idx); end
    tests++; if (rdata2 !== 16'h1234) begin fails++; $display("FAIL sweep_rdata got %h want 1234", rdata2); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_read_all();
    test_busy_reject();
    test_mid_reset();
    test_back_to_back();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
